alu_issue_arb: RTL and testbench

ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_rr_pick.sv | 28 ++
 rtl/alu_issue_arb.sv | 132 +++++++++++++
 tb/tb_alu_issue_arb.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode map and opcode legality check.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam logic [3:0]  OP_MAX     = 4'b1000;
  localparam int unsigned FLAG_WIDTH = 5;

  typedef enum logic [3:0] {
    AluAddSub = 4'd0,
    AluSll    = 4'd1,
    AluSlt    = 4'd2,
    AluSltu   = 4'd3,
    AluXor    = 4'd4,
    AluSrx    = 4'd5,
    AluOr     = 4'd6,
    AluAnd    = 4'd7,
    AluInt2Fp = 4'd8
  } alu_op_e;

  // Opcodes above the highest legal one are still issued but flagged.
  function automatic logic is_illegal(input logic [3:0] op, input logic [3:0] op_max);
    return op > op_max;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: one-hot grant plus the priority pointer for next cycle.
module alu_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       prio_o
);

  // Grant the sole requester, or the prioritised one on contention; pointer flips past winner.
  always_comb begin
    grant_o = 2'b00;
    prio_o  = prio_i;
    if (enable_i) begin
      if (valid_i == 2'b11) begin
        grant_o = prio_i ? 2'b10 : 2'b01;
      end else begin
        grant_o = valid_i;
      end
    end
    if (grant_o[0]) begin
      prio_o = 1'b1;
    end else if (grant_o[1]) begin
      prio_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_arb.sv
// Two-requester issue arbiter in front of a shared combinational ALU.
// S1 holds the operands driving the ALU, S2 registers the ALU result as the response.
module alu_issue_arb #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter logic [3:0]  OP_MAX     = alu_pkg::OP_MAX
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  input  logic                            in_req_valid_0,
  output logic                            out_req_ready_0,
  input  logic [DATA_WIDTH-1:0]           in_rs1_0,
  input  logic [DATA_WIDTH-1:0]           in_rs2_0,
  input  logic [3:0]                      in_op_0,
  input  logic [1:0]                      in_fmt_0,
  input  logic                            in_output_fmt_0,
  input  logic                            in_sub_ctrl_0,
  input  logic                            in_req_valid_1,
  output logic                            out_req_ready_1,
  input  logic [DATA_WIDTH-1:0]           in_rs1_1,
  input  logic [DATA_WIDTH-1:0]           in_rs2_1,
  input  logic [3:0]                      in_op_1,
  input  logic [1:0]                      in_fmt_1,
  input  logic                            in_output_fmt_1,
  input  logic                            in_sub_ctrl_1,
  output logic [DATA_WIDTH-1:0]           out_alu_rs1,
  output logic [DATA_WIDTH-1:0]           out_alu_rs2,
  output logic [3:0]                      out_alu_op,
  output logic [1:0]                      out_alu_fmt,
  output logic                            out_alu_output_fmt,
  output logic                            out_alu_sub_ctrl,
  input  logic [DATA_WIDTH-1:0]           in_alu_data,
  input  logic [alu_pkg::FLAG_WIDTH-1:0]  in_alu_flag,
  output logic                            out_rsp_valid,
  input  logic                            in_rsp_ready,
  output logic                            out_rsp_id,
  output logic [DATA_WIDTH-1:0]           out_rsp_data,
  output logic [alu_pkg::FLAG_WIDTH-1:0]  out_rsp_flag,
  output logic                            out_rsp_illegal
);

  import alu_pkg::*;

  logic       s2_free;
  logic       s1_adv;
  logic       s1_en;
  logic [1:0] grant;
  logic       prio_q, prio_d;
  logic       s1_valid_q, s1_valid_d;
  logic       s1_id_q;
  logic       rsp_valid_d;

  // Pipeline flow control; reset forces the request side closed immediately.
  always_comb begin
    s2_free = !out_rsp_valid || in_rsp_ready;
    s1_adv  = s1_valid_q && s2_free;
    s1_en   = (!s1_valid_q || s2_free) && !in_rst;
  end

  alu_rr_pick u_pick (
    .valid_i  ({in_req_valid_1, in_req_valid_0}),
    .prio_i   (prio_q),
    .enable_i (s1_en),
    .grant_o  (grant),
    .prio_o   (prio_d)
  );

  assign out_req_ready_0 = grant[0];
  assign out_req_ready_1 = grant[1];

  // Stage occupancy: a new accept refills S1, otherwise advancing empties it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (|grant) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    rsp_valid_d = out_rsp_valid;
    if (s1_adv) begin
      rsp_valid_d = 1'b1;
    end else if (in_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // S1: operand register for the granted requester; holds contents when not loading.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      s1_valid_q         <= 1'b0;
      s1_id_q            <= 1'b0;
      prio_q             <= 1'b0;
      out_alu_rs1        <= '0;
      out_alu_rs2        <= '0;
      out_alu_op         <= '0;
      out_alu_fmt        <= '0;
      out_alu_output_fmt <= 1'b0;
      out_alu_sub_ctrl   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prio_q     <= prio_d;
      if (|grant) begin
        s1_id_q            <= grant[1];
        out_alu_rs1        <= grant[1] ? in_rs1_1        : in_rs1_0;
        out_alu_rs2        <= grant[1] ? in_rs2_1        : in_rs2_0;
        out_alu_op         <= grant[1] ? in_op_1         : in_op_0;
        out_alu_fmt        <= grant[1] ? in_fmt_1        : in_fmt_0;
        out_alu_output_fmt <= grant[1] ? in_output_fmt_1 : in_output_fmt_0;
        out_alu_sub_ctrl   <= grant[1] ? in_sub_ctrl_1   : in_sub_ctrl_0;
      end
    end
  end

  // S2: captures the ALU result of S1; frozen while the response is stalled.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_rsp_valid   <= 1'b0;
      out_rsp_id      <= 1'b0;
      out_rsp_data    <= '0;
      out_rsp_flag    <= '0;
      out_rsp_illegal <= 1'b0;
    end else begin
      out_rsp_valid <= rsp_valid_d;
      if (s1_adv) begin
        out_rsp_id      <= s1_id_q;
        out_rsp_data    <= in_alu_data;
        out_rsp_flag    <= in_alu_flag;
        out_rsp_illegal <= is_illegal(out_alu_op, OP_MAX);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: scenario tasks plus randomized traffic against a queue model.
module tb_alu_issue_arb;

  localparam int DW = 64;

  typedef struct {
    logic          v;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [3:0]    op;
    logic [1:0]    fmt;
    logic          ofmt;
    logic          sub;
  } req_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [4:0]    flag;
    logic          ill;
    int            acc;
  } exp_t;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b0;
  logic          in_rsp_ready = 1'b0;
  req_t          rq [2];
  logic          out_req_ready_0, out_req_ready_1;
  logic [DW-1:0] out_alu_rs1, out_alu_rs2, in_alu_data, out_rsp_data;
  logic [3:0]    out_alu_op;
  logic [1:0]    out_alu_fmt;
  logic          out_alu_output_fmt, out_alu_sub_ctrl;
  logic [4:0]    in_alu_flag, out_rsp_flag;
  logic          out_rsp_valid, out_rsp_id, out_rsp_illegal;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   m_prio = 0;
  int   cyc = 0;
  int   m_acc = 0;
  int   win;
  logic e_acc, e_r0, e_r1, e_rv;

  always #5 in_clk = ~in_clk;

  alu_issue_arb dut (
    .in_clk             (in_clk),
    .in_rst             (in_rst),
    .in_req_valid_0     (rq[0].v),
    .out_req_ready_0    (out_req_ready_0),
    .in_rs1_0           (rq[0].rs1),
    .in_rs2_0           (rq[0].rs2),
    .in_op_0            (rq[0].op),
    .in_fmt_0           (rq[0].fmt),
    .in_output_fmt_0    (rq[0].ofmt),
    .in_sub_ctrl_0      (rq[0].sub),
    .in_req_valid_1     (rq[1].v),
    .out_req_ready_1    (out_req_ready_1),
    .in_rs1_1           (rq[1].rs1),
    .in_rs2_1           (rq[1].rs2),
    .in_op_1            (rq[1].op),
    .in_fmt_1           (rq[1].fmt),
    .in_output_fmt_1    (rq[1].ofmt),
    .in_sub_ctrl_1      (rq[1].sub),
    .out_alu_rs1        (out_alu_rs1),
    .out_alu_rs2        (out_alu_rs2),
    .out_alu_op         (out_alu_op),
    .out_alu_fmt        (out_alu_fmt),
    .out_alu_output_fmt (out_alu_output_fmt),
    .out_alu_sub_ctrl   (out_alu_sub_ctrl),
    .in_alu_data        (in_alu_data),
    .in_alu_flag        (in_alu_flag),
    .out_rsp_valid      (out_rsp_valid),
    .in_rsp_ready       (in_rsp_ready),
    .out_rsp_id         (out_rsp_id),
    .out_rsp_data       (out_rsp_data),
    .out_rsp_flag       (out_rsp_flag),
    .out_rsp_illegal    (out_rsp_illegal)
  );

  // External ALU stand-in: {flag, data}; opcodes above 8 yield zero data.
  function automatic logic [67:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [1:0] fmt,
                                            input logic ofmt, input logic sub);
    logic [DW-1:0] d;
    d = '0;
    case (op)
      4'd0: d = sub ? a - b : a + b;
      4'd1: d = a << b[5:0];
      4'd2: d = {63'b0, $signed(a) < $signed(b)};
      4'd3: d = {63'b0, a < b};
      4'd4: d = a ^ b;
      4'd5: d = sub ? $unsigned($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      4'd6: d = a | b;
      4'd7: d = a & b;
      4'd8: d = {a[31:0], 30'b0, fmt};
      default: d = '0;
    endcase
    return {ofmt, fmt, d == '0, d};
  endfunction

  always_comb {in_alu_flag, in_alu_data} = alu_model(out_alu_op, out_alu_rs1, out_alu_rs2,
                                                     out_alu_fmt, out_alu_output_fmt,
                                                     out_alu_sub_ctrl);

  task automatic new_req(input int n, input logic v);
    rq[n].v    = v;
    rq[n].rs1  = {$urandom, $urandom};
    rq[n].rs2  = {$urandom, $urandom};
    rq[n].op   = 4'($urandom_range(0, 15));
    rq[n].fmt  = 2'($urandom);
    rq[n].ofmt = 1'($urandom);
    rq[n].sub  = 1'($urandom);
  endtask

  // Model view: up to two ops in flight; the oldest is visible one edge after its accept.
  task automatic predict();
    logic allowed;
    win     = (rq[0].v && rq[1].v) ? m_prio : (rq[1].v ? 1 : 0);
    allowed = (q.size() < 2) || in_rsp_ready;
    e_acc   = !in_rst && (rq[0].v || rq[1].v) && allowed;
    e_r0    = e_acc && (win == 0);
    e_r1    = e_acc && (win == 1);
    e_rv    = !in_rst && (q.size() > 0) && (q[0].acc < cyc);
  endtask

  task automatic tick();
    exp_t e;
    logic [67:0] r;
    predict();
    @(posedge in_clk);
    if (!in_rst) begin
      cyc++;
      if (e_rv && in_rsp_ready) void'(q.pop_front());
      if (e_acc) begin
        r      = alu_model(rq[win].op, rq[win].rs1, rq[win].rs2, rq[win].fmt,
                           rq[win].ofmt, rq[win].sub);
        e.id   = 1'(win);
        e.data = r[63:0];
        e.flag = r[67:64];
        e.ill  = rq[win].op > 4'd8;
        e.acc  = cyc;
        q.push_back(e);
        m_prio = 1 - win;
        m_acc++;
      end
    end
    @(negedge in_clk);
  endtask

  task automatic test_reset();
    #1 in_rst = 1'b1;
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    in_rsp_ready = 1'b1;
    @(negedge in_clk);
    @(negedge in_clk);
    total++;
    if ({out_req_ready_0, out_req_ready_1, out_rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valids: got %b want 000",
               {out_req_ready_0, out_req_ready_1, out_rsp_valid});
    end
    total++;
    if ({out_alu_rs1, out_alu_rs2, out_alu_op, out_alu_fmt, out_alu_output_fmt,
         out_alu_sub_ctrl} !== '0) begin
      bad++;
      $display("FAIL reset_alu: got op=%h rs1=%h rs2=%h want zero", out_alu_op, out_alu_rs1,
               out_alu_rs2);
    end
    total++;
    if ({out_rsp_id, out_rsp_data, out_rsp_flag, out_rsp_illegal} !== '0) begin
      bad++;
      $display("FAIL reset_rsp: got id=%b data=%h flag=%h ill=%b want zero", out_rsp_id,
               out_rsp_data, out_rsp_flag, out_rsp_illegal);
    end
    in_rst = 1'b0;
    #1;
    total++;
    if ({out_req_ready_0, out_req_ready_1} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_grant: got r0=%b r1=%b want r0=1 r1=0", out_req_ready_0,
               out_req_ready_1);
    end
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
  endtask

  task automatic test_single();
    rq[0] = '{v: 1'b1, rs1: 64'd5, rs2: 64'd3, op: 4'd0, fmt: 2'd0, ofmt: 1'b0, sub: 1'b0};
    rq[1].v = 1'b0;
    in_rsp_ready = 1'b1;
    #1;
    total++;
    if ({out_req_ready_0, out_req_ready_1} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready: got r0=%b r1=%b want 1 0", out_req_ready_0, out_req_ready_1);
    end
    tick();
    rq[0].v = 1'b0;
    #1;
    total++;
    if (out_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early: got rsp_valid=%b want 0", out_rsp_valid);
    end
    tick();
    #1;
    total++;
    if ({out_rsp_valid, out_rsp_id, out_rsp_data, out_rsp_illegal} !== {1'b1, 1'b0, 64'd8, 1'b0})
    begin
      bad++;
      $display("FAIL single_rsp: got v=%b id=%b data=%0d ill=%b want v=1 id=0 data=8 ill=0",
               out_rsp_valid, out_rsp_id, out_rsp_data, out_rsp_illegal);
    end
    tick();
  endtask

  task automatic test_alternate();
    in_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      new_req(0, i < 8);
      new_req(1, i < 8);
      #1 predict();
      total++;
      if ({out_req_ready_0, out_req_ready_1} !== {e_r0, e_r1}) begin
        bad++;
        $display("FAIL alt_ready[%0d]: got %b%b want %b%b", i, out_req_ready_0,
                 out_req_ready_1, e_r0, e_r1);
      end
      total++;
      if (out_rsp_valid !== e_rv) begin
        bad++;
        $display("FAIL alt_rsp_valid[%0d]: got %b want %b", i, out_rsp_valid, e_rv);
      end else if (e_rv) begin
        total++;
        if ({out_rsp_id, out_rsp_data, out_rsp_flag, out_rsp_illegal} !==
            {q[0].id, q[0].data, q[0].flag, q[0].ill}) begin
          bad++;
          $display("FAIL alt_rsp[%0d]: got id=%b data=%h want id=%b data=%h", i, out_rsp_id,
                   out_rsp_data, q[0].id, q[0].data);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    in_rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        in_rsp_ready = 1'b1;
        rq[0].v = 1'b0;
        rq[1].v = 1'b0;
      end
      #1 predict();
      total++;
      if ({out_req_ready_0, out_req_ready_1} !== {e_r0, e_r1}) begin
        bad++;
        $display("FAIL stall_ready[%0d]: got %b%b want %b%b", i, out_req_ready_0,
                 out_req_ready_1, e_r0, e_r1);
      end
      total++;
      if (out_rsp_valid !== e_rv) begin
        bad++;
        $display("FAIL stall_rsp_valid[%0d]: got %b want %b", i, out_rsp_valid, e_rv);
      end else if (e_rv) begin
        total++;
        if ({out_rsp_id, out_rsp_data, out_rsp_flag, out_rsp_illegal} !==
            {q[0].id, q[0].data, q[0].flag, q[0].ill}) begin
          bad++;
          $display("FAIL stall_rsp[%0d]: got id=%b data=%h want id=%b data=%h", i, out_rsp_id,
                   out_rsp_data, q[0].id, q[0].data);
        end
      end
      if (i == 4) begin
        total++;
        if (q.size() != 2 || {out_req_ready_0, out_req_ready_1} !== 2'b00) begin
          bad++;
          $display("FAIL stall_buffered: got model=%0d ready=%b%b want 2 buffered ready=00",
                   q.size(), out_req_ready_0, out_req_ready_1);
        end
      end
      tick();
    end
    total++;
    if (q.size() != 0 || out_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain: got pending=%0d rsp_valid=%b want 0 0", q.size(),
               out_rsp_valid);
    end
  endtask

  task automatic test_illegal();
    new_req(1, 1'b1);
    rq[1].op = 4'b1010;
    rq[0].v = 1'b0;
    in_rsp_ready = 1'b1;
    tick();
    rq[1].v = 1'b0;
    tick();
    #1;
    total++;
    if ({out_rsp_valid, out_rsp_id, out_rsp_data, out_rsp_illegal} !== {1'b1, 1'b1, 64'd0, 1'b1})
    begin
      bad++;
      $display("FAIL illegal_rsp: got v=%b id=%b data=%h ill=%b want v=1 id=1 data=0 ill=1",
               out_rsp_valid, out_rsp_id, out_rsp_data, out_rsp_illegal);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    in_rsp_ready = 1'b0;
    tick();
    tick();
    #2 in_rst = 1'b1;
    #1;
    total++;
    if ({out_rsp_valid, out_req_ready_0, out_req_ready_1, out_alu_op, out_rsp_data} !== '0)
    begin
      bad++;
      $display("FAIL rstmid_clear: got v=%b r=%b%b op=%h data=%h want all zero", out_rsp_valid,
               out_req_ready_0, out_req_ready_1, out_alu_op, out_rsp_data);
    end
    q.delete();
    m_prio = 0;
    @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
    in_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (out_rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_stale[%0d]: got rsp_valid=%b want 0", i, out_rsp_valid);
      end
      tick();
    end
    rq[0].v = 1'b1;
    rq[1].v = 1'b1;
    #1;
    total++;
    if ({out_req_ready_0, out_req_ready_1} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_prio: got r0=%b r1=%b want 1 0", out_req_ready_0, out_req_ready_1);
    end
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
  endtask

  task automatic test_random();
    int   base = m_acc;
    int   guard = 0;
    int   waits [2] = '{0, 0};
    logic last_acc [2] = '{1'b0, 1'b0};
    logic rdy [2];
    while (m_acc - base < 10000 && guard < 30000) begin
      for (int n = 0; n < 2; n++)
        if (!rq[n].v || last_acc[n]) new_req(n, $urandom_range(0, 3) != 0);
      in_rsp_ready = $urandom_range(0, 3) != 0;
      #1 predict();
      rdy[0] = out_req_ready_0;
      rdy[1] = out_req_ready_1;
      total++;
      if ({rdy[0], rdy[1]} !== {e_r0, e_r1}) begin
        bad++;
        $display("FAIL rand_ready@%0d: got %b%b want %b%b", guard, rdy[0], rdy[1], e_r0, e_r1);
      end
      total++;
      if (out_rsp_valid !== e_rv) begin
        bad++;
        $display("FAIL rand_rsp_valid@%0d: got %b want %b", guard, out_rsp_valid, e_rv);
      end else if (e_rv) begin
        total++;
        if ({out_rsp_id, out_rsp_data, out_rsp_flag, out_rsp_illegal} !==
            {q[0].id, q[0].data, q[0].flag, q[0].ill}) begin
          bad++;
          $display("FAIL rand_rsp@%0d: got id=%b data=%h flag=%h want id=%b data=%h flag=%h",
                   guard, out_rsp_id, out_rsp_data, out_rsp_flag, q[0].id, q[0].data,
                   q[0].flag);
        end
      end
      // A waiting requester may see the other side granted at most once.
      for (int n = 0; n < 2; n++) begin
        if (rdy[n] === 1'b1 || !rq[n].v) waits[n] = 0;
        else if (rdy[1-n] === 1'b1) waits[n]++;
        if (waits[n] > 1) begin
          total++;
          bad++;
          $display("FAIL rand_starve@%0d: got req%0d passed over %0d times want <=1", guard, n,
                   waits[n]);
          waits[n] = 0;
        end
      end
      tick();
      last_acc[0] = e_r0;
      last_acc[1] = e_r1;
      guard++;
    end
    total++;
    if (m_acc - base < 10000) begin
      bad++;
      $display("FAIL rand_budget: got %0d accepts want 10000", m_acc - base);
    end
    rq[0].v = 1'b0;
    rq[1].v = 1'b0;
    in_rsp_ready = 1'b1;
    repeat (4) tick();
    #1;
    total++;
    if (q.size() != 0 || out_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_drain: got pending=%0d rsp_valid=%b want 0 0", q.size(),
               out_rsp_valid);
    end
  endtask

  initial begin
    rq[0] = '{v: 1'b0, rs1: '0, rs2: '0, op: '0, fmt: '0, ofmt: 1'b0, sub: 1'b0};
    rq[1] = '{v: 1'b0, rs1: '0, rs2: '0, op: '0, fmt: '0, ofmt: 1'b0, sub: 1'b0};
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
